onehot_enc_sync: RTL and testbench



---
 rtl/onehot_enc_sync_pkg.sv | 39 +++
 rtl/onehot_enc_sync_if.sv | 28 ++
 rtl/onehot_enc_sync_classify.sv | 16 +
 rtl/onehot_enc_sync.sv | 120 ++++++++++++
 tb/tb_onehot_enc_sync.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/onehot_enc_sync_pkg.sv
// Shared types for the one-hot encoder: buffer fill state, entry record and classifier.
package onehot_enc_pkg;

   localparam int unsigned MAX_N  = 64;
   localparam int unsigned MAX_IW = $clog2(MAX_N);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } fill_t;

   typedef struct packed {
      logic [MAX_IW-1:0] idx;
      logic              zero;
      logic              multi;
   } entry_t;

   // Lowest set bit wins; any further set bit marks the vector multi-hot.
   function automatic entry_t classify_vec(input logic [MAX_N-1:0] vec);
      entry_t e;
      logic   found;
      e     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (vec[i]) begin
            if (found) begin
               e.multi = 1'b1;
            end else begin
               e.idx = MAX_IW'(i);
               found = 1'b1;
            end
         end
      end
      e.zero = ~found;
      return e;
   endfunction

endpackage

// File: rtl/onehot_enc_sync_if.sv
// Valid/ready bus of the one-hot encoder; slave is the encoder side, master the driver side.
interface onehot_enc_sync_if #(
   parameter int unsigned N     = 2,
   parameter int unsigned CNT_W = 8
);
   localparam int unsigned IW = $clog2(N);

   logic [N-1:0]     in_vec;
   logic             in_valid;
   logic             in_ready;
   logic [IW-1:0]    out_idx;
   logic             out_zero;
   logic             out_multi;
   logic             out_valid;
   logic             out_ready;
   logic             err_clr;
   logic [CNT_W-1:0] err_count;

   modport slave (
      input  in_vec, in_valid, out_ready, err_clr,
      output in_ready, out_idx, out_zero, out_multi, out_valid, err_count
   );

   modport master (
      output in_vec, in_valid, out_ready, err_clr,
      input  in_ready, out_idx, out_zero, out_multi, out_valid, err_count
   );
endinterface

// File: rtl/onehot_enc_sync_classify.sv
// Combinational flag-vector classifier: lowest-set index plus zero/multi-hot flags.
module onehot_enc_classify
   import onehot_enc_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0] vec,
   output entry_t       entry
);

   logic [MAX_N-1:0] vec_ext;

   assign vec_ext = MAX_N'(vec);
   assign entry   = classify_vec(vec_ext);

endmodule

// File: rtl/onehot_enc_sync.sv
// Registered one-hot encoder with a 2-entry output buffer and saturating error counter.
// Define ONEHOT_ENC_STRICT_EN to count but drop zero/multi-hot vectors instead of buffering them.
module onehot_enc_sync
   import onehot_enc_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   onehot_enc_sync_if.slave    bus
);

   localparam int unsigned IW = $clog2(N);

   fill_t            state_q, state_d;
   entry_t           head_q, tail_q, cls;
   logic             rdy_q;
   logic [CNT_W-1:0] err_q;
   logic             out_valid, in_ready, push, pop, keep, is_err;
   logic             load_head, load_tail, head_from_tail;
   logic             unused_bits;

   onehot_enc_classify #(.N(N)) u_classify (
      .vec   (bus.in_vec),
      .entry (cls)
   );

   assign out_valid = (state_q != EMPTY);
   // rdy_q keeps in_ready low during reset while state already reads EMPTY
   assign in_ready  = rdy_q & (state_q != FULL);
   assign push      = bus.in_valid & in_ready;
   assign pop       = out_valid & bus.out_ready;
   assign is_err    = cls.zero | cls.multi;

`ifdef ONEHOT_ENC_STRICT_EN
   assign keep          = ~is_err;
   assign bus.out_zero  = 1'b0;
   assign bus.out_multi = 1'b0;
`else
   assign keep          = 1'b1;
   assign bus.out_zero  = out_valid & head_q.zero;
   assign bus.out_multi = out_valid & head_q.multi;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_idx   = out_valid ? head_q.idx[IW-1:0] : '0;
   assign bus.err_count = err_q;
   assign unused_bits   = ^{head_q, tail_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      load_head      = 1'b0;
      load_tail      = 1'b0;
      head_from_tail = 1'b0;
      case (state_q)
         EMPTY: begin
            if (push && keep) begin
               state_d   = ONE;
               load_head = 1'b1;
            end
         end
         ONE: begin
            if (push && keep && !pop) begin
               state_d   = FULL;
               load_tail = 1'b1;
            end else if (push && keep && pop) begin
               load_head = 1'b1;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d        = ONE;
               head_from_tail = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (load_head) begin
            head_q <= cls;
         end else if (head_from_tail) begin
            head_q <= tail_q;
         end
         if (load_tail) begin
            tail_q <= cls;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else if (bus.err_clr) begin
         err_q <= '0;
      end else if (push && is_err && (err_q != '1)) begin
         err_q <= err_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_onehot_enc_sync.sv
// Directed bench for onehot_enc_sync (N=2, CNT_W=2); follows ONEHOT_ENC_STRICT_EN if defined.
module tb_onehot_enc_sync;

`ifdef ONEHOT_ENC_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   typedef struct {
      logic [1:0] vec;
      logic       idx;
      logic       zero;
      logic       multi;
      logic [1:0] err;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   vec_t tbl[5];

   onehot_enc_sync_if #(.N(2), .CNT_W(2)) bus ();

   onehot_enc_sync #(.N(2), .CNT_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      tbl[0] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1] = '{2'b10, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[2] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'd1};
      tbl[3] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'd2};
      tbl[4] = '{2'b10, 1'b1, 1'b0, 1'b0, 2'd2};

      rst_n         = 1'b0;
      bus.in_vec    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.err_clr   = 1'b0;

      // reset state
      step();
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready",  32'(bus.in_ready), 0);
      chk("rst_out_idx",   32'(bus.out_idx), 0);
      chk("rst_out_zero",  32'(bus.out_zero), 0);
      chk("rst_out_multi", 32'(bus.out_multi), 0);
      chk("rst_err",       32'(bus.err_count), 0);
      #3 rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", 32'(bus.in_ready), 1);

      // back-to-back table pushes with out_ready=1
      for (int i = 0; i < 5; i++) begin
         bus.in_vec   = tbl[i].vec;
         bus.in_valid = 1'b1;
         step();
         chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid),
             32'(!(STRICT && (tbl[i].zero || tbl[i].multi))));
         chk($sformatf("tbl%0d_idx", i),   32'(bus.out_idx), 32'(tbl[i].idx));
         chk($sformatf("tbl%0d_zero", i),  32'(bus.out_zero), 32'(tbl[i].zero && !STRICT));
         chk($sformatf("tbl%0d_multi", i), 32'(bus.out_multi), 32'(tbl[i].multi && !STRICT));
         chk($sformatf("tbl%0d_err", i),   32'(bus.err_count), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_rdy", i),   32'(bus.in_ready), 1);
      end
      bus.in_valid = 1'b0;
      step();
      chk("tbl_drain_valid", 32'(bus.out_valid), 0);

      // backpressure: 01,10 fill the buffer, third vector waits
      bus.out_ready = 1'b0;
      bus.in_vec    = 2'b01;
      bus.in_valid  = 1'b1;
      step();
      chk("bp1_idx", 32'(bus.out_idx), 0);
      chk("bp1_rdy", 32'(bus.in_ready), 1);
      bus.in_vec = 2'b10;
      step();
      chk("bp2_rdy", 32'(bus.in_ready), 0);
      bus.in_vec = 2'b01;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("bp_hold_valid", 32'(bus.out_valid), 1);
         chk("bp_hold_idx",   32'(bus.out_idx), 0);
         chk("bp_hold_rdy",   32'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_out2_idx", 32'(bus.out_idx), 1);
      chk("bp_out2_rdy", 32'(bus.in_ready), 1);
      // ONE with simultaneous push and pop: new entry becomes head
      step();
      bus.in_valid = 1'b0;
      chk("bp_out3_valid", 32'(bus.out_valid), 1);
      chk("bp_out3_idx",   32'(bus.out_idx), 0);
      step();
      chk("bp_empty", 32'(bus.out_valid), 0);

      // saturation at 3 with CNT_W=2
      bus.err_clr = 1'b1;
      step();
      chk("clr_err", 32'(bus.err_count), 0);
      bus.err_clr  = 1'b0;
      bus.in_vec   = 2'b00;
      bus.in_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk($sformatf("sat%0d_err", i), 32'(bus.err_count), 32'((i > 3) ? 3 : i));
      end
      bus.err_clr = 1'b1;
      step();
      chk("clr_prio_err",  32'(bus.err_count), 0);
      chk("clr_prio_zero", 32'(bus.out_zero), 32'(!STRICT));
      bus.err_clr  = 1'b0;
      bus.in_valid = 1'b0;
      step();

      // fill to FULL with err_count nonzero, then reset mid-cycle
      bus.in_vec   = 2'b00;
      bus.in_valid = 1'b1;
      step();
      bus.in_vec = 2'b01;
      step();
      bus.out_ready = 1'b0;
      bus.in_vec    = 2'b10;
      step();
      bus.in_valid = 1'b0;
      chk("full_rdy", 32'(bus.in_ready), 0);
      chk("full_err", 32'(bus.err_count), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_rdy",   32'(bus.in_ready), 0);
      chk("mid_rst_err",   32'(bus.err_count), 0);
      step();
      #3 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      step();
      chk("rel_rdy",   32'(bus.in_ready), 1);
      chk("rel_valid", 32'(bus.out_valid), 0);
      bus.in_vec   = 2'b10;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("rel_push_valid", 32'(bus.out_valid), 1);
      chk("rel_push_idx",   32'(bus.out_idx), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
